baud_tick_gen: RTL
==================

# baud_tick_gen

Parametrised baud-rate tick generator serving both UART Tx and Rx paths from one system clock. A fixed-point fractional divider produces a single-cycle oversample tick (`tick_os`) and a bit tick (`tick_bit`) every `OVERSAMPLE` oversample ticks. Rates come from four compile-time presets or a runtime-loaded custom divisor. An Rx resync input realigns bit phase to a detected start-bit edge.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz; used for preset divisor computation.
- `OVERSAMPLE`, default 16: oversample ticks per bit; even, range 4–32.
- `DIV_W`, default 16: integer bits of the divisor.
- `FRAC_W`, default 4: fractional bits of the divisor. `D` is the full divisor, `DIV_W+FRAC_W` bits wide, in units of 1/2^FRAC_W clock cycles.
- `clock`, in, 1: system clock, rising edge. One clock; reset is asynchronous and active-low.
- `reset_n`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: run generator; when low, all counters are held cleared.
- `baud_rate`, in, 2: preset select: 00=2400, 01=4800, 10=9600, 11=19200.
- `use_custom`, in, 1: 1 selects the custom divisor register instead of the preset.
- `div_load`, in, 1: one-cycle strobe; loads `div_value` into the custom register.
- `div_value`, in, DIV_W+FRAC_W: custom divisor `D`.
- `resync`, in, 1: one-cycle strobe; realigns to mid-bit.
- `tick_os`, out, 1: one-cycle oversample pulse.
- `tick_bit`, out, 1: one-cycle bit pulse, coincident with a `tick_os`.
- `baud_clk`, out, 1: registered square wave at the bit rate; high during the first half of each bit.

## Operation
- Preset `D` = round(CLK_HZ·2^FRAC_W / (baud·OVERSAMPLE)). At defaults: 2400→20833, 4800→10417, 9600→5208 (325+8/16), 19200→2604 (162+12/16).
- Effective `D_eff`:
  - selected by `use_custom`;
  - any value below 2·2^FRAC_W (integer part < 2) is clamped to 2·2^FRAC_W.
- Phase accumulator `acc`, DIV_W+FRAC_W+1 bits, evaluated each enabled cycle:
  - `sum = acc + 2^FRAC_W`;
  - if `sum >= D_eff`: `acc <= sum − D_eff`, `tick_os` asserted next cycle;
  - otherwise `acc <= sum`.
  - The `tick_os` period alternates between floor(D/2^FRAC_W) and ceil(D/2^FRAC_W) cycles; the mean is exact.
- Oversample counter `os_cnt`, range 0..OVERSAMPLE−1, advances on each `tick_os`. The wrap from OVERSAMPLE−1 to 0 asserts `tick_bit` together with that `tick_os`.
- `baud_clk` = registered (`os_cnt < OVERSAMPLE/2`) while enabled; 0 while disabled.
- Restart occurs on any of:
  - `div_load`;
  - a change of `baud_rate` or `use_custom` (compared against registered copies);
  - a rising edge of `enable`.
  - Restart clears `acc` and `os_cnt`. The first `tick_os` follows D_eff/2^FRAC_W cycles later (rounded per the accumulator).
- `resync` sets `os_cnt` to OVERSAMPLE/2 and clears `acc`, so the next `tick_bit` lands half a bit later (mid-bit sample point).
- Same-cycle priority: reset > `enable` low > restart > `resync` > normal count.
- `div_load` while `use_custom`=0 updates the register and still restarts.

## Timing
- Reset values:
  - `tick_os`, `tick_bit`, `baud_clk` = 0;
  - `acc` = 0, `os_cnt` = 0;
  - custom register = 9600 preset (5208 at defaults).
- All outputs are registered. With `D_eff`=N·2^FRAC_W, the first `tick_os` is high exactly N cycles after the restart cycle, then every N cycles.
- `tick_os` and `tick_bit` are never high for two consecutive cycles, given the clamp at D = 2.0.
- `enable` falling: outputs are 0 from the next cycle; no partial tick is emitted.
- Reset asserted mid-bit: outputs go to 0 asynchronously; counting resumes from a clean restart after `reset_n` rises.

## Configuration
- `BAUD_FRAC_EN` defined: fractional bits of `D_eff` are honoured, as described above.
- `BAUD_FRAC_EN` undefined:
  - the low FRAC_W bits of `D_eff` are forced to 0 before clamping, giving pure integer division;
  - presets truncate to their integer part (9600 → period 325);
  - port widths are unchanged.

## Structure
- Package `baud_pkg` holds:
  - `baud_sel_e` enum (BAUD24, BAUD48, BAUD96, BAUD192);
  - the `preset_div(CLK_HZ, OVERSAMPLE, FRAC_W, sel)` constant function;
  - the default FRAC_W localparam.
- Sub-module `baud_frac_acc`:
  - contains the phase accumulator and clamp;
  - inputs: `D_eff`, `run`, `clear`; output: `tick`.
  - The top level holds the divisor select, change detection, `os_cnt`, `resync` and `baud_clk`.

## Test plan
- Reset, `enable`=1, `baud_rate`=11, defaults → `tick_os` intervals alternate 162/163 cycles (12 of every 16 are 163); `tick_bit` every 2604 cycles on average, ±1 cycle.
- `use_custom`=1, load `div_value`=32 (2.0) → `tick_os` every 2 cycles, `tick_bit` every 32; load 5 → clamped, same behaviour.
- Mid-bit switch of `baud_rate` 10→00 → `os_cnt` restarts; next `tick_os` 1302 cycles after the change cycle (20833/16 rounded per the accumulator).
- `resync` pulse at `os_cnt`=3 → next `tick_bit` after exactly 8 `tick_os` pulses.
- `enable` dropped mid-bit then raised, and `reset_n` pulsed mid-bit → outputs 0 immediately; first `tick_os` N cycles after re-enable.
- Build without `BAUD_FRAC_EN`, `baud_rate`=10 → `tick_os` period constant at 325 cycles.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared types and preset divisor computation for the baud tick generator.
package baud_pkg;

  localparam int unsigned FRAC_W_DEF = 4;

  typedef enum logic [1:0] {
    BAUD24  = 2'b00,
    BAUD48  = 2'b01,
    BAUD96  = 2'b10,
    BAUD192 = 2'b11
  } baud_sel_e;

  // round(clk_hz * 2^frac_w / (baud * oversample)), in 1/2^frac_w clock units
  function automatic longint unsigned preset_div(
    input longint unsigned clk_hz,
    input int unsigned     oversample,
    input int unsigned     frac_w,
    input baud_sel_e       sel
  );
    longint unsigned baud;
    longint unsigned num;
    longint unsigned den;
    unique case (sel)
      BAUD24:  baud = 64'd2400;
      BAUD48:  baud = 64'd4800;
      BAUD96:  baud = 64'd9600;
      BAUD192: baud = 64'd19200;
    endcase
    num = clk_hz << frac_w;
    den = baud * 64'(oversample);
    return (num + den / 64'd2) / den;
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fixed-point phase accumulator with divisor clamp; emits one tick per D_eff.
// BAUD_FRAC_EN keeps the fractional divisor bits, otherwise they are dropped.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [DIV_W+FRAC_W-1:0] D_eff,
  input  logic                    run,
  input  logic                    clear,
  output logic                    tick,
  output logic                    tick_c
);

  localparam int unsigned DW = DIV_W + FRAC_W;
  localparam int unsigned AW = DW + 1;
  localparam logic [DW-1:0] D_MIN = DW'(64'd2 << FRAC_W);
  localparam logic [AW-1:0] STEP  = AW'(64'd1 << FRAC_W);
`ifndef BAUD_FRAC_EN
  localparam logic [DW-1:0] FRAC_MASK = DW'((64'd1 << FRAC_W) - 64'd1);
`endif

  logic [DW-1:0] d_int;
  logic [DW-1:0] d_cl;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic          hit;

  // Integer-only builds drop the fraction before clamping to 2.0
  always_comb begin
`ifdef BAUD_FRAC_EN
    d_int = D_eff;
`else
    d_int = D_eff & ~FRAC_MASK;
`endif
    d_cl   = (d_int < D_MIN) ? D_MIN : d_int;
    sum    = acc + STEP;
    hit    = (sum >= {1'b0, d_cl});
    tick_c = run & ~clear & hit;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (run) begin
      tick <= hit;
      acc  <= hit ? (sum - {1'b0, d_cl}) : sum;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: divisor select, restart detection, oversample counter.
// BAUD_FRAC_EN enables fractional divisors; undefined gives integer division.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = FRAC_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [1:0]              baud_rate,
  input  logic                    use_custom,
  input  logic                    div_load,
  input  logic [DIV_W+FRAC_W-1:0] div_value,
  input  logic                    resync,
  output logic                    tick_os,
  output logic                    tick_bit,
  output logic                    baud_clk
);

  localparam int unsigned DW   = DIV_W + FRAC_W;
  localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

  localparam logic [DW-1:0] PRE_24  = DW'(preset_div(64'(CLK_HZ), OVERSAMPLE, FRAC_W, BAUD24));
  localparam logic [DW-1:0] PRE_48  = DW'(preset_div(64'(CLK_HZ), OVERSAMPLE, FRAC_W, BAUD48));
  localparam logic [DW-1:0] PRE_96  = DW'(preset_div(64'(CLK_HZ), OVERSAMPLE, FRAC_W, BAUD96));
  localparam logic [DW-1:0] PRE_192 = DW'(preset_div(64'(CLK_HZ), OVERSAMPLE, FRAC_W, BAUD192));

  logic [DW-1:0]   custom_div;
  logic [1:0]      baud_q;
  logic            custom_q;
  logic            enable_q;
  logic [OS_W-1:0] os_cnt;
  logic [OS_W-1:0] os_nxt;
  logic            bit_nxt;
  logic [DW-1:0]   d_pre;
  logic [DW-1:0]   d_sel;
  logic            restart_c;
  logic            acc_clear;
  logic            tick_c;

  always_comb begin
    unique case (baud_sel_e'(baud_rate))
      BAUD24:  d_pre = PRE_24;
      BAUD48:  d_pre = PRE_48;
      BAUD96:  d_pre = PRE_96;
      BAUD192: d_pre = PRE_192;
    endcase
    d_sel = use_custom ? custom_div : d_pre;
  end

  // Any rate change or re-enable restarts the bit from a clean phase
  assign restart_c = div_load | (baud_rate != baud_q) | (use_custom != custom_q)
                   | (enable & ~enable_q);
  assign acc_clear = ~enable | restart_c | resync;

  baud_frac_acc #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clock   (clock),
    .reset_n (reset_n),
    .D_eff   (d_sel),
    .run     (enable),
    .clear   (acc_clear),
    .tick    (tick_os),
    .tick_c  (tick_c)
  );

  // Priority: disabled > restart > resync > normal count
  always_comb begin
    os_nxt  = os_cnt;
    bit_nxt = 1'b0;
    if (!enable) begin
      os_nxt = '0;
    end else if (restart_c) begin
      os_nxt = '0;
    end else if (resync) begin
      os_nxt = OS_HALF;
    end else if (tick_c) begin
      if (os_cnt == OS_LAST) begin
        os_nxt  = '0;
        bit_nxt = 1'b1;
      end else begin
        os_nxt = os_cnt + OS_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      custom_div <= PRE_96;
      baud_q     <= 2'b00;
      custom_q   <= 1'b0;
      enable_q   <= 1'b0;
      os_cnt     <= '0;
      tick_bit   <= 1'b0;
      baud_clk   <= 1'b0;
    end else begin
      if (div_load) custom_div <= div_value;
      baud_q   <= baud_rate;
      custom_q <= use_custom;
      enable_q <= enable;
      os_cnt   <= os_nxt;
      tick_bit <= bit_nxt;
      baud_clk <= enable & (os_nxt < OS_HALF);
    end
  end

endmodule
